// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//
// Loop-back monitor for a multiplexed 4-digit, common-anode 7-segment
// display bus. It watches the active-low digit enables and segment lines,
// waits for each one-hot digit sample to stay still for STABLE_CYC edges,
// decodes the segment pattern back into a hex nibble and assembles a frame.
// Once all four digits have been captured, the frame is published.
//
// Parameters:
//   STABLE_CYC  - number of consecutive edges a one-hot sample must hold
//                 before it is captured (legal range 2..255)
//
// Ports:
//   clk          - system clock, all logic on the rising edge
//   rst          - synchronous active-high reset
//   an[3:0]      - digit enables, active-low (an[i]=0 selects digit i)
//   hex[6:0]     - segments, active-low, hex[6]=g ... hex[0]=a
//   digits[15:0] - last complete frame, digit i at digits[4*i+3:4*i]
//   digit_err[3:0] - per-digit undecodable flag for the last frame
//   frame_valid  - one-cycle pulse when digits/digit_err are updated
//   pat_err      - one-cycle pulse when an undecodable pattern is captured

module seg_scan_decoder #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  hex,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        pat_err
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);
  localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYC - 1);

  // Reverse segment lookup. Returns {error, nibble}; an unknown pattern
  // reads as nibble F with the error bit set, while an all-dark digit is a
  // legitimate blank that also maps to F but without error.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] result;
    result = 5'b1_1111;
    case (pat)
      7'b1000000: result = 5'h00;
      7'b1111001: result = 5'h01;
      7'b0100100: result = 5'h02;
      7'b0110000: result = 5'h03;
      7'b0011001: result = 5'h04;
      7'b0010010: result = 5'h05;
      7'b0000010: result = 5'h06;
      7'b1111000: result = 5'h07;
      7'b0000000: result = 5'h08;
      7'b0010000: result = 5'h09;
      7'b0001000: result = 5'h0A;
      7'b0000011: result = 5'h0B;
      7'b1000110: result = 5'h0C;
      7'b0100001: result = 5'h0D;
      7'b0000110: result = 5'h0E;
      7'b1111111: result = 5'h0F;
      default:    result = 5'b1_1111;
    endcase
    return result;
  endfunction

  logic [3:0]  prev_an;
  logic [6:0]  prev_hex;
  logic [7:0]  run;
  logic [15:0] buffer;
  logic [3:0]  buffer_err;
  logic [3:0]  seen;

  logic        one_hot;
  logic [1:0]  sel;
  logic        same;
  logic [7:0]  run_next;
  logic        capture;
  logic [4:0]  decoded;
  logic [15:0] buffer_next;
  logic [3:0]  buffer_err_next;
  logic [3:0]  seen_next;
  logic        frame_done;

  // Recognise a single active digit enable and turn it into a digit index.
  // Blanking (all high) and multi-digit enables are not captureable.
  always_comb begin
    one_hot = 1'b0;
    sel     = 2'd0;
    case (an)
      4'b1110: begin one_hot = 1'b1; sel = 2'd0; end
      4'b1101: begin one_hot = 1'b1; sel = 2'd1; end
      4'b1011: begin one_hot = 1'b1; sel = 2'd2; end
      4'b0111: begin one_hot = 1'b1; sel = 2'd3; end
      default: begin one_hot = 1'b0; sel = 2'd0; end
    endcase
  end

  // Stability run length. The count saturates at STABLE_CYC so that a
  // digit held for a long time is captured exactly once; any change in the
  // sample restarts the count.
  always_comb begin
    same     = ({an, hex} == {prev_an, prev_hex});
    run_next = 8'd0;
    if (one_hot && same) begin
      if (run >= STABLE_MAX) begin
        run_next = STABLE_MAX;
      end else begin
        run_next = run + 8'd1;
      end
    end else if (one_hot) begin
      run_next = 8'd1;
    end
    capture = one_hot && same && (run == STABLE_PRE);
  end

  // Merge the freshly decoded digit into the assembly buffer. The frame
  // completes on the capture that fills the last missing digit, so the
  // published frame has to come from the merged value, not the old buffer.
  always_comb begin
    decoded         = decode_seg(hex);
    buffer_next     = buffer;
    buffer_err_next = buffer_err;
    buffer_next[{sel, 2'b00} +: 4] = decoded[3:0];
    buffer_err_next[sel]           = decoded[4];
    seen_next  = seen | (4'b0001 << sel);
    frame_done = capture && (seen_next == 4'hF);
  end

  // State and output registers. All outputs are registered so nothing on
  // the display pins reaches the outputs combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_an     <= 4'hF;
      prev_hex    <= 7'h7F;
      run         <= 8'd0;
      buffer      <= 16'h0000;
      buffer_err  <= 4'h0;
      seen        <= 4'h0;
      digits      <= 16'h0000;
      digit_err   <= 4'h0;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
    end else begin
      prev_an     <= an;
      prev_hex    <= hex;
      run         <= run_next;
      frame_valid <= frame_done;
      pat_err     <= capture && decoded[4];
      if (capture) begin
        buffer     <= buffer_next;
        buffer_err <= buffer_err_next;
        if (frame_done) begin
          digits    <= buffer_next;
          digit_err <= buffer_err_next;
          seen      <= 4'h0;
        end else begin
          seen      <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//
// Self-checking bench for seg_scan_decoder. A behavioural model tracks how
// long the current display sample has been held, decodes captured digits by
// searching the segment table and builds frames; a compare process checks
// every DUT output against it on each falling edge. Directed scans pin the
// model with hand-computed frames and pulse counts.

module tb_seg_scan_decoder;

  localparam int STABLE_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  hex;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        pat_err;

  int n_vec = 0;
  int n_mis = 0;
  int fv_count = 0;
  int pe_count = 0;
  bit chk_en = 1'b0;

  seg_scan_decoder #(.STABLE_CYC(STABLE_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .hex         (hex),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .pat_err     (pat_err)
  );

  always #5 clk = ~clk;

  // Segment patterns for 0..F; the index is the nibble value.
  logic [6:0] seg_table [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b1111111
  };

  // Model state
  int          hold_len = 0;
  logic [10:0] last_sample = {4'hF, 7'h7F};
  bit   [3:0]  m_seen = 4'h0;
  logic [3:0]  m_buf [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  bit   [3:0]  m_buf_err = 4'h0;
  logic [15:0] m_digits = 16'h0000;
  logic [3:0]  m_err = 4'h0;
  bit          m_fv = 1'b0;
  bit          m_pe = 1'b0;

  // Behavioural model: counts how many edges the same single-digit sample
  // has been seen in a row and captures on the edge where that count first
  // reaches STABLE_CYC.
  always @(posedge clk) begin
    int zeros;
    int d;
    int nib;
    bit bad;
    if (rst) begin
      hold_len    = 0;
      last_sample = {4'hF, 7'h7F};
      m_seen      = 4'h0;
      m_buf_err   = 4'h0;
      for (int i = 0; i < 4; i++) m_buf[i] = 4'h0;
      m_digits    = 16'h0000;
      m_err       = 4'h0;
      m_fv        = 1'b0;
      m_pe        = 1'b0;
    end else begin
      m_fv  = 1'b0;
      m_pe  = 1'b0;
      zeros = 0;
      d     = 0;
      for (int i = 0; i < 4; i++) begin
        if (an[i] == 1'b0) begin
          zeros++;
          d = i;
        end
      end
      if (zeros == 1 && {an, hex} == last_sample) hold_len++;
      else if (zeros == 1) hold_len = 1;
      else hold_len = 0;
      if (zeros == 1 && hold_len == STABLE_CYC) begin
        nib = 15;
        bad = 1'b1;
        for (int v = 0; v < 16; v++) begin
          if (seg_table[v] == hex) begin
            nib = v;
            bad = 1'b0;
          end
        end
        m_buf[d]     = nib[3:0];
        m_buf_err[d] = bad;
        m_seen[d]    = 1'b1;
        m_pe         = bad;
        if (m_seen == 4'hF) begin
          m_digits = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          m_err    = m_buf_err;
          m_fv     = 1'b1;
          m_seen   = 4'h0;
        end
      end
      last_sample = {an, hex};
    end
  end

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are stable between rising edges, so they are
  // checked against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("digits", digits, m_digits);
      check_output("digit_err", {12'h0, digit_err}, {12'h0, m_err});
      check_output("frame_valid", {15'h0, frame_valid}, {15'h0, m_fv});
      check_output("pat_err", {15'h0, pat_err}, {15'h0, m_pe});
      if (frame_valid === 1'b1) fv_count++;
      if (pat_err === 1'b1) pe_count++;
    end
  end

  // Drive a sample and hold it for n rising edges; returns on a falling edge.
  task automatic apply_stimulus(input logic [3:0] a, input logic [6:0] h, input int n);
    an  = a;
    hex = h;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    an  = 4'b0101;
    hex = 7'h2A;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    apply_stimulus(4'hF, 7'h7F, 10);
    check_output("reset_digits", digits, 16'h0000);
    check_output("reset_fv_count", 16'(fv_count), 16'd0);
    check_output("reset_pe_count", 16'(pe_count), 16'd0);

    // Clean scan 1,2,3,4
    apply_stimulus(4'b1110, 7'b1111001, 4);
    apply_stimulus(4'b1101, 7'b0100100, 4);
    apply_stimulus(4'b1011, 7'b0110000, 4);
    apply_stimulus(4'b0111, 7'b0011001, 4);
    check_output("clean_fv", {15'h0, frame_valid}, 16'h0001);
    check_output("clean_digits", digits, 16'h4321);
    check_output("clean_err", {12'h0, digit_err}, 16'h0000);
    apply_stimulus(4'hF, 7'h7F, 2);
    check_output("clean_fv_count", 16'(fv_count), 16'd1);

    // Glitch: digit 2 too short, then re-presented
    apply_stimulus(4'b1110, 7'b1111001, 4);
    apply_stimulus(4'b1101, 7'b0100100, 4);
    apply_stimulus(4'b1011, 7'b0110000, 3);
    apply_stimulus(4'b0111, 7'b0011001, 4);
    check_output("glitch_no_fv", {15'h0, frame_valid}, 16'h0000);
    apply_stimulus(4'b1011, 7'b0110000, 4);
    check_output("glitch_fv", {15'h0, frame_valid}, 16'h0001);
    check_output("glitch_digits", digits, 16'h4321);
    apply_stimulus(4'hF, 7'h7F, 2);
    check_output("glitch_fv_count", 16'(fv_count), 16'd2);

    // Bad pattern on digit 1
    apply_stimulus(4'b1110, 7'b1000000, 4);
    apply_stimulus(4'b1101, 7'b1010101, 4);
    check_output("bad_pat_err", {15'h0, pat_err}, 16'h0001);
    apply_stimulus(4'b1011, 7'b0010000, 4);
    apply_stimulus(4'b0111, 7'b0000110, 4);
    check_output("bad_fv", {15'h0, frame_valid}, 16'h0001);
    check_output("bad_digits", digits, 16'hE9F0);
    check_output("bad_err", {12'h0, digit_err}, 16'h0002);
    apply_stimulus(4'hF, 7'h7F, 2);
    check_output("bad_pe_count", 16'(pe_count), 16'd1);
    check_output("bad_fv_count", 16'(fv_count), 16'd3);

    // Illegal and blank enables with changing and steady segments
    for (int i = 0; i < 20; i++) apply_stimulus(4'b1100, 7'($urandom), 1);
    apply_stimulus(4'b0000, 7'b1111001, 8);
    for (int i = 0; i < 20; i++) apply_stimulus(4'b1111, 7'($urandom), 1);
    check_output("illegal_fv_count", 16'(fv_count), 16'd3);
    check_output("illegal_pe_count", 16'(pe_count), 16'd1);
    apply_stimulus(4'b1110, 7'b0001000, 4);
    apply_stimulus(4'b1101, 7'b0000011, 4);
    apply_stimulus(4'b1011, 7'b1000110, 4);
    apply_stimulus(4'b0111, 7'b0100001, 4);
    check_output("after_illegal_digits", digits, 16'hDCBA);
    check_output("after_illegal_err", {12'h0, digit_err}, 16'h0000);
    apply_stimulus(4'hF, 7'h7F, 2);
    check_output("after_illegal_fv_count", 16'(fv_count), 16'd4);

    // Reset mid-frame discards digits 0..2
    apply_stimulus(4'b1110, 7'b0010010, 4);
    apply_stimulus(4'b1101, 7'b0000010, 4);
    apply_stimulus(4'b1011, 7'b1111000, 4);
    rst = 1'b1;
    apply_stimulus(4'hF, 7'h7F, 1);
    rst = 1'b0;
    check_output("midreset_digits", digits, 16'h0000);
    apply_stimulus(4'b0111, 7'b0000000, 10);
    apply_stimulus(4'hF, 7'h7F, 2);
    check_output("midreset_fv_count", 16'(fv_count), 16'd4);
    apply_stimulus(4'b1110, 7'b0010010, 4);
    apply_stimulus(4'b1101, 7'b0000010, 4);
    apply_stimulus(4'b1011, 7'b1111000, 4);
    check_output("rescan_fv", {15'h0, frame_valid}, 16'h0001);
    check_output("rescan_digits", digits, 16'h8765);
    apply_stimulus(4'hF, 7'h7F, 2);
    check_output("rescan_fv_count", 16'(fv_count), 16'd5);
    check_output("final_pe_count", 16'(pe_count), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
